tag_queue_mp: RTL
=================

Name: tag_queue_mp

Overview:
- Multi-push, single-pop in-order tag queue for the Tomasulo dispatch path. Holds ROB/RS tags in program order for the memory-ordering and commit logic.
- Compared with the plain tag FIFO it adds:
  - any DEPTH, with explicit pointer wrap;
  - PUSH_PORTS-wide dispatch per cycle;
  - occupancy, full, empty and almost-full status;
  - a misprediction flush;
  - sticky overflow and underflow error flags.

Parameters:
- DEPTH, default 8: number of entries, ≥2, power of two not required.
- TAG_WIDTH, default 4: width of each tag.
- PUSH_PORTS, default 2: pushes accepted per cycle, 1..DEPTH.
- AFULL_THRESH, default 6: almost_full asserts when count ≥ AFULL_THRESH.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- flush  in  1  synchronous clear of all entries (branch mispredict).
- push_valid  in  PUSH_PORTS  per-port push request; must be contiguous from bit 0.
- push_tag  in  PUSH_PORTS*TAG_WIDTH  packed tags; port i occupies bits [i*TAG_WIDTH +: TAG_WIDTH].
- push_ready  out  1  high when free ≥ PUSH_PORTS.
- pop  in  1  dequeue the head entry.
- front_valid  out  1  head entry valid (= !empty).
- front_tag  out  TAG_WIDTH  head tag; 0 when empty.
- count  out  $clog2(DEPTH+1)  current occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AFULL_THRESH.
- err_overflow  out  1  sticky flag.
- err_underflow  out  1  sticky flag.
- err_clear  in  1  synchronous clear of both sticky flags.

Behaviour:
- Reset (asynchronous, takes effect immediately, also mid-operation):
  - head=0, tail=0, count=0.
  - Error flags = 0.
  - Outputs: empty=1, front_valid=0, front_tag=0, push_ready=1 (for any PUSH_PORTS ≤ DEPTH).
  - Storage contents are don't-care.
- Pointers:
  - Range 0..DEPTH-1; advancing past DEPTH-1 wraps to 0.
  - Advancing by k computes (p+k) mod DEPTH without a divider, using compare-and-subtract since k ≤ DEPTH.
- Push acceptance:
  - n = popcount(push_valid).
  - If n ≤ free (free = DEPTH - count, registered value, with no credit for a same-cycle pop), all n tags are written at tail..tail+n-1 (wrapped, port 0 first) and tail advances by n.
  - If n > free, the whole group is dropped (all-or-nothing) and err_overflow is set.
  - Non-contiguous push_valid (a hole below a set bit) is illegal: the group is dropped and err_overflow is set.
- Pop:
  - If pop and !empty: head advances by 1.
  - If pop and empty: ignored, err_underflow is set.
- Simultaneous push and pop: both apply; count_next = count + n_accepted - popped.
- Latency:
  - A tag pushed at cycle t appears on front_tag in cycle t+1 at the earliest.
  - No combinational bypass from push_tag to front_tag.
  - front_tag is a combinational read of mem[head].
- Status outputs:
  - count, full, empty, almost_full and push_ready are derived from registered count only.
  - They do not depend combinationally on push_valid or pop.
- Flush:
  - Priority: reset > flush > push/pop.
  - On a flush cycle, head=tail=count=0 and that cycle's pushes and pops are discarded.
  - Error flags are not set by a flush and are not altered by it.
- err_clear:
  - Clears both flags at the clock edge.
  - If a new error occurs in the same cycle, the flag stays set (set wins).

Decomposition:
- Shared package tomasulo_pkg holds:
  - typedef tag_t (logic [TAG_WIDTH-1:0]);
  - the TAG_WIDTH default constant;
  - function ptr_adv(ptr, k, DEPTH) for wrapped pointer advance.
- No sub-module. Popcount, the contiguity check and the write-enable decode stay inline.

Test Plan (DEPTH=4, PUSH_PORTS=2, TAG_WIDTH=4, AFULL_THRESH=3):
1. After reset, push_valid=2'b11 with tags 0x3 and 0x7, then idle.
   -> Next cycle: count=2, front_tag=3.
   -> Two pops -> front_tag=7, then empty=1, front_tag=0.
2. Fill to 3 (tags 1, 2, 3), then push 2'b11.
   -> Group dropped, count stays 3, err_overflow=1.
   -> almost_full=1 and push_ready=0 throughout.
3. Wrap-around: push 2, pop 2, push 2'b11 (tags A, B), then push 2'b11 (tags C, D).
   -> count=4, full=1.
   -> Pops return A, B, C, D in order; tail wraps through 3→0.
4. At count=2, same cycle push 2'b01 (tag 5) and pop.
   -> count stays 2.
   -> Head advances; tag 5 is stored at the old tail.
5. At count=3, assert flush together with push 2'b11 and pop.
   -> Next cycle count=0, empty=1, no error flags set.
6. Pop on empty -> err_underflow=1.
   - Then err_clear together with another pop on empty -> flag remains 1.
   - Then err_clear alone -> flag 0.
   - Assert reset asynchronously between clock edges -> outputs return to reset values immediately.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared types and helpers for the Tomasulo dispatch/commit tag path.
package tomasulo_pkg;

  localparam int TAG_WIDTH_DEF = 4;

  typedef logic [TAG_WIDTH_DEF-1:0] tag_t;

  // Wrapped pointer advance: callers guarantee ptr < depth and k <= depth,
  // so a single compare-and-subtract replaces the modulo.
  function automatic int unsigned ptr_adv(input int unsigned ptr,
                                          input int unsigned k,
                                          input int unsigned depth);
    int unsigned s;
    s = ptr + k;
    if (s >= depth) s = s - depth;
    return s;
  endfunction

endpackage

// File: rtl/tag_queue_mp.sv
// Multi-push, single-pop in-order tag queue for dispatch ordering.
// Single-cycle visibility; push groups accepted all-or-nothing against registered free space.
module tag_queue_mp
  import tomasulo_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int TAG_WIDTH    = TAG_WIDTH_DEF,
  parameter int PUSH_PORTS   = 2,
  parameter int AFULL_THRESH = 6
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush,
  input  logic [PUSH_PORTS-1:0]           push_valid,
  input  logic [PUSH_PORTS*TAG_WIDTH-1:0] push_tag,
  output logic                            push_ready,
  input  logic                            pop,
  output logic                            front_valid,
  output logic [TAG_WIDTH-1:0]            front_tag,
  output logic [$clog2(DEPTH+1)-1:0]      count,
  output logic                            full,
  output logic                            empty,
  output logic                            almost_full,
  output logic                            err_overflow,
  output logic                            err_underflow,
  input  logic                            err_clear
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [CNT_W-1:0]     r_count;
  logic [TAG_WIDTH-1:0] r_mem [DEPTH];
  logic                 r_err_ovf;
  logic                 r_err_unf;

  logic [CNT_W-1:0]      w_n;
  logic [CNT_W-1:0]      w_free;
  logic [PUSH_PORTS-1:0] w_mask;
  logic                  w_contig;
  logic                  w_push_acc;
  logic                  w_pop_acc;
  logic                  w_ovf;
  logic                  w_unf;
  logic                  w_empty;
  logic [PTR_W-1:0]      w_wr_addr [PUSH_PORTS];
  logic [CNT_W-1:0]      w_count_next;

  always_comb begin
    w_n    = '0;
    w_mask = '0;
    for (int i = 0; i < PUSH_PORTS; i++) begin
      w_n = w_n + CNT_W'(push_valid[i]);
    end
    // A legal group is exactly the low n bits set; anything else has a hole.
    for (int i = 0; i < PUSH_PORTS; i++) begin
      w_mask[i] = (i < int'(w_n));
    end
    w_contig = (push_valid == w_mask);
    w_free   = CNT_W'(DEPTH) - r_count;
    w_empty  = (r_count == '0);

    w_push_acc = !flush && (w_n != '0) && w_contig && (w_n <= w_free);
    w_ovf      = !flush && (w_n != '0) && (!w_contig || (w_n > w_free));
    w_pop_acc  = !flush && pop && !w_empty;
    w_unf      = !flush && pop && w_empty;

    for (int i = 0; i < PUSH_PORTS; i++) begin
      w_wr_addr[i] = PTR_W'(ptr_adv(int'(r_tail), i, DEPTH));
    end

    w_count_next = r_count
                 + (w_push_acc ? w_n : '0)
                 - (w_pop_acc ? CNT_W'(1) : '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_acc) r_tail <= PTR_W'(ptr_adv(int'(r_tail), int'(w_n), DEPTH));
      if (w_pop_acc)  r_head <= PTR_W'(ptr_adv(int'(r_head), 1, DEPTH));
      r_count <= w_count_next;
    end
  end

  // Flush cycles leave the sticky flags untouched; otherwise a new error beats err_clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_ovf <= 1'b0;
      r_err_unf <= 1'b0;
    end else if (!flush) begin
      r_err_ovf <= w_ovf || (r_err_ovf && !err_clear);
      r_err_unf <= w_unf || (r_err_unf && !err_clear);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < PUSH_PORTS; i++) begin
      if (w_push_acc && push_valid[i]) begin
        r_mem[w_wr_addr[i]] <= push_tag[i*TAG_WIDTH +: TAG_WIDTH];
      end
    end
  end

  assign count         = r_count;
  assign empty         = w_empty;
  assign full          = (r_count == CNT_W'(DEPTH));
  assign almost_full   = (int'(r_count) >= AFULL_THRESH);
  assign push_ready    = (int'(w_free) >= PUSH_PORTS);
  assign front_valid   = !w_empty;
  assign front_tag     = w_empty ? '0 : r_mem[r_head];
  assign err_overflow  = r_err_ovf;
  assign err_underflow = r_err_unf;

endmodule
